tx_frame_builder: RTL and testbench
===================================

# tx_frame_builder

Parametrised TX framer and symbol mapper. It is the successor to the fixed QPSK-plus-header transmit path. It takes raw bit pairs from an AXI-Stream-style input and maps them to BPSK or QPSK symbols, selected per frame. Each frame is emitted as a PN7 BPSK header, a fixed-length payload and a zero-symbol guard gap. The output is a registered AXI-Stream-style IQ stream feeding the DAC/interpolation chain.

## Interface
- IQ_W, 12, signed width of each of I and Q
- AMP, 1024, mapped symbol magnitude; must satisfy 0 < AMP < 2^(IQ_W-1)
- HDR_LEN, 32, header symbols per frame, >= 1
- PAY_LEN, 256, payload symbols per frame, >= 1
- GAP_LEN, 8, zero symbols after payload, >= 1
- HDR_SEED, 7'h5B, PN7 LFSR seed, nonzero
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only on the IDLE->HDR transition
- in_valid  in  1  input bit pair valid
- in_bits  in  2  [1] = I bit, [0] = Q bit; BPSK uses in_bits[0] only
- in_ready  out  1  input accepted when in_valid && in_ready
- out_valid  out  1  output symbol valid
- out_data  out  2*IQ_W  {I, Q}, I in upper half, two's complement
- out_ready  in  1  downstream ready
- out_last  out  1  qualifies the final payload symbol of a frame
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, HDR, PAY, GAP.
- Output register load enable: ld = !out_valid || out_ready. Every symbol enters the output register on ld. The counter cnt counts loads only.
- IDLE:
  - out_valid is cleared on the next ld; in_ready = 0.
  - When in_valid = 1, latch mode into mode_r, reseed the LFSR to HDR_SEED, set cnt = 0 and go to HDR.
  - The triggering input is not consumed.
- HDR:
  - On each ld, load I = (lfsr[6] ? -AMP : +AMP), Q = 0, then step the LFSR: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - After HDR_LEN loads, go to PAY with cnt = 0.
  - in_ready = 0.
- PAY:
  - in_ready = ld. On a transfer, load the mapped symbol.
  - Mapping: bit 0 -> +AMP, bit 1 -> -AMP.
    - QPSK: I from in_bits[1], Q from in_bits[0].
    - BPSK: I from in_bits[0], Q = 0.
  - If in_valid = 0 while ld = 1, out_valid clears: a bubble, no filler symbol is inserted.
  - The PAY_LEN-th load sets out_last with that symbol and moves to GAP.
- GAP:
  - On each ld, load I = Q = 0 with out_last = 0.
  - After GAP_LEN loads, return to IDLE.
  - in_ready = 0.
- The mode input is ignored outside the IDLE->HDR transition. A mid-frame change has no effect on the current frame.
- Counter width is $clog2 of max(HDR_LEN, PAY_LEN, GAP_LEN) + 1.

## Timing
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, out_valid = 0, out_data = 0, out_last = 0, busy = 0, in_ready = 0.
  - LFSR = HDR_SEED, cnt = 0, mode_r = 0.
- Leaving reset: first edge with rst_n = 1 behaves as normal IDLE.
- Frame start latency: in_valid sampled high at edge k (IDLE->HDR). The first header symbol is loaded at edge k+1, so out_valid is high from k+1.
- Frame length with out_ready held high and no input gaps: exactly HDR_LEN + PAY_LEN + GAP_LEN consecutive valid cycles.
- Next frame start: after the last GAP load, state = IDLE. If in_valid is still high, HDR is entered one edge later, so there is exactly one idle (out_valid = 0) cycle between frames.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and out_last are held stable. The LFSR, cnt and state freeze, and in_ready = 0.
- in_ready is combinational from state and ld. There is no combinational path from in_valid to out_valid or out_data.
- Simultaneous in_valid drop and out_ready high in PAY: the held symbol is consumed and out_valid falls at the next edge.
- Reset mid-frame: immediate return to the reset values. A partially sent frame is abandoned, and the next frame restarts from the header with HDR_SEED.

## Test plan
- Reset: assert rst_n = 0 mid-PAY with out_valid = 1 -> out_valid, out_last and busy are 0 asynchronously, without waiting for a clock edge; out_data = 0.
- Header pattern: defaults, out_ready = 1, in_valid = 1 -> first three symbols are out_data = {-1024, 0}, {+1024, 0}, {-1024, 0}; exactly 32 header symbols follow the k+1 latency.
- QPSK payload: mode = 1, bit pairs 2'b00, 2'b01, 2'b10, 2'b11 -> {+1024, +1024}, {+1024, -1024}, {-1024, +1024}, {-1024, -1024}. The 256th payload symbol has out_last = 1, followed by 8 cycles of {0, 0}.
- BPSK with a mid-frame mode flip: mode = 0 at frame start, switched to 1 during HDR, in_bits = 2'b10 -> payload is {+1024, 0}; the frame stays BPSK.
- Backpressure: random out_ready at 50% duty -> out_data is stable while stalled. The frame contains exactly 32 + 256 + 8 transfers, in_ready transfers total 256, and the input order is preserved.
- Underflow: in_valid = 0 for 5 cycles mid-PAY -> out_valid is low for those cycles, no symbol is inserted, and the payload count still ends at 256 with a single out_last.

Source files
------------

// File: rtl/tx_frame_builder.sv
// TX framer: PN7 BPSK header, BPSK/QPSK mapped payload and zero guard gap,
// presented on a registered valid/ready IQ stream.
module tx_frame_builder #(
    parameter int         IQ_W     = 12,
    parameter int         AMP      = 1024,
    parameter int         HDR_LEN  = 32,
    parameter int         PAY_LEN  = 256,
    parameter int         GAP_LEN  = 8,
    parameter logic [6:0] HDR_SEED = 7'h5B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [1:0]        in_bits,
    output logic              in_ready,
    output logic              out_valid,
    output logic [2*IQ_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);
    localparam int MAX_HP  = (HDR_LEN > PAY_LEN) ? HDR_LEN : PAY_LEN;
    localparam int MAX_LEN = (MAX_HP > GAP_LEN) ? MAX_HP : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] HDR_END = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_END = CNT_W'(PAY_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IQ_W-1:0]  POS     = IQ_W'(AMP);
    localparam logic [IQ_W-1:0]  NEG     = IQ_W'(-AMP);
    localparam logic [IQ_W-1:0]  ZERO    = IQ_W'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [6:0]        lfsr_r, lfsr_s;
    logic              mode_r, mode_s;
    logic              valid_s, last_s;
    logic [2*IQ_W-1:0] data_s;
    logic              ld_s;

    // Bit 0 maps to +AMP, bit 1 to -AMP.
    function automatic logic [IQ_W-1:0] map_bit(input logic b);
        return b ? NEG : POS;
    endfunction

    assign ld_s     = !out_valid || out_ready;
    assign in_ready = (state_r == PAY) && ld_s;
    assign busy     = (state_r != IDLE);

    // Next-state, LFSR, counter and output-register next values
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        lfsr_s  = lfsr_r;
        mode_s  = mode_r;
        valid_s = out_valid;
        data_s  = out_data;
        last_s  = out_last;
        case (state_r)
            IDLE: begin
                if (ld_s) begin
                    valid_s = 1'b0;
                    data_s  = {ZERO, ZERO};
                    last_s  = 1'b0;
                end else begin
                    valid_s = out_valid;
                end
                // Start trigger is not consumed; the payload bits come later in PAY.
                if (in_valid) begin
                    mode_s  = mode;
                    lfsr_s  = HDR_SEED;
                    cnt_s   = CNT_ZERO;
                    state_s = HDR;
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                if (ld_s) begin
                    valid_s = 1'b1;
                    data_s  = {map_bit(lfsr_r[6]), ZERO};
                    last_s  = 1'b0;
                    lfsr_s  = {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
                    if (cnt_r == HDR_END) begin
                        cnt_s   = CNT_ZERO;
                        state_s = PAY;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = HDR;
                end
            end
            PAY: begin
                if (ld_s) begin
                    if (in_valid) begin
                        valid_s = 1'b1;
                        data_s  = mode_r ? {map_bit(in_bits[1]), map_bit(in_bits[0])}
                                         : {map_bit(in_bits[0]), ZERO};
                        if (cnt_r == PAY_END) begin
                            last_s  = 1'b1;
                            cnt_s   = CNT_ZERO;
                            state_s = GAP;
                        end else begin
                            last_s = 1'b0;
                            cnt_s  = cnt_r + CNT_ONE;
                        end
                    end else begin
                        // Underflow bubble: drop valid rather than inventing a symbol.
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                    end
                end else begin
                    state_s = PAY;
                end
            end
            GAP: begin
                if (ld_s) begin
                    valid_s = 1'b1;
                    data_s  = {ZERO, ZERO};
                    last_s  = 1'b0;
                    if (cnt_r == GAP_END) begin
                        cnt_s   = CNT_ZERO;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State, LFSR, counter and registered output stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            lfsr_r    <= HDR_SEED;
            mode_r    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= {ZERO, ZERO};
            out_last  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            lfsr_r    <= lfsr_s;
            mode_r    <= mode_s;
            out_valid <= valid_s;
            out_data  <= data_s;
            out_last  <= last_s;
        end
    end
endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: mapping table, header pattern, frame
// framing, backpressure, underflow, back-to-back frames and mid-frame reset.
`timescale 1ns/1ps
module tb_tx_frame_builder;
    localparam int HDR   = 32;
    localparam int PAY   = 256;
    localparam int GAP   = 8;
    localparam int FRAME = HDR + PAY + GAP;
    localparam logic [11:0] POS    = 12'h400;
    localparam logic [11:0] NEG    = 12'hC00;
    localparam logic [11:0] ZERO12 = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n, mode, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [1:0]  in_bits;
    logic [23:0] out_data;

    tx_frame_builder dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_bits(in_bits),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       md;
        logic [1:0] bits;
        logic [11:0] ei;
        logic [11:0] eq;
    } vec_t;

    vec_t        vt[6];
    logic [1:0]  pay_bits[PAY];
    logic [23:0] obs_d[$];
    logic        obs_l[$];
    logic [1:0]  in_q[$];
    int          first_v, last_v, bubbles, stall_err, pass_cnt, total_cnt;
    logic        timeout, end_busy;

    task automatic check_v(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [23:0] get_d(input int i);
        if (i < obs_d.size()) return obs_d[i];
        else return 24'hxxxxxx;
    endfunction

    function automatic logic get_l(input int i);
        if (i < obs_l.size()) return obs_l[i];
        else return 1'bx;
    endfunction

    // Drives one frame and records every output / input transfer.
    task automatic run_frame(input logic md, input logic flip, input logic rnd,
                             input int uf_at, input logic hold);
        int   cyc = 0;
        int   uf_left = 0;
        logic uf_done = 1'b0;
        logic prev_stall = 1'b0;
        logic prev_l = 1'b0;
        logic [23:0] prev_d = 24'd0;
        obs_d.delete(); obs_l.delete(); in_q.delete();
        first_v = -1; last_v = -1; bubbles = 0; stall_err = 0; timeout = 1'b0;
        @(posedge clk); #1;
        mode = md; in_valid = 1'b1; in_bits = pay_bits[0];
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stall_err++;
            if (out_valid && !out_ready && in_ready) stall_err++;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end else if (first_v >= 0 && obs_d.size() < FRAME) begin
                bubbles++;
            end
            end_busy = busy;
            if (obs_d.size() >= FRAME && !out_valid) break;
            if (cyc >= 4000) begin
                timeout = 1'b1;
                break;
            end
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
            end
            if (in_valid && in_ready) in_q.push_back(in_bits);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            @(posedge clk); #1;
            cyc++;
            if (flip && obs_d.size() == 5) mode = ~md;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (uf_at >= 0 && !uf_done && in_q.size() == uf_at) begin
                uf_left = 5;
                uf_done = 1'b1;
            end
            in_bits = pay_bits[in_q.size() % PAY];
            if (uf_left > 0) begin
                in_valid = 1'b0;
                uf_left--;
            end else begin
                in_valid = hold || (in_q.size() < PAY);
            end
        end
        check_i("timeout", int'(timeout), 0);
    endtask

    // Compares the recorded frame against an independent frame model.
    task automatic check_frame(input logic md, input string tag);
        logic [6:0]  l = 7'h5B;
        logic [23:0] e;
        logic        el;
        logic [1:0]  b;
        int derr = 0;
        int lerr = 0;
        for (int i = 0; i < FRAME; i++) begin
            el = 1'b0;
            if (i < HDR) begin
                e = {(l[6] ? NEG : POS), ZERO12};
                l = {l[5:0], l[6] ^ l[5]};
            end else if (i < HDR + PAY) begin
                b  = pay_bits[i - HDR];
                e  = md ? {(b[1] ? NEG : POS), (b[0] ? NEG : POS)} : {(b[0] ? NEG : POS), ZERO12};
                el = (i == HDR + PAY - 1);
            end else begin
                e = 24'd0;
            end
            if (get_d(i) !== e) begin
                if (derr == 0) $display("  %s: first data diff at symbol %0d got %h want %h", tag, i, get_d(i), e);
                derr++;
            end
            if (get_l(i) !== el) lerr++;
        end
        check_i({tag, "_xfers"}, obs_d.size(), FRAME);
        check_i({tag, "_data"}, derr, 0);
        check_i({tag, "_last"}, lerr, 0);
    endtask

    initial begin
        int errs;
        int found;
        pass_cnt = 0; total_cnt = 0;
        vt[0] = '{1'b1, 2'b00, POS, POS};
        vt[1] = '{1'b1, 2'b01, POS, NEG};
        vt[2] = '{1'b1, 2'b10, NEG, POS};
        vt[3] = '{1'b1, 2'b11, NEG, NEG};
        vt[4] = '{1'b0, 2'b10, POS, ZERO12};
        vt[5] = '{1'b0, 2'b01, NEG, ZERO12};

        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_bits = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_v("rst_out_valid", 64'(out_valid), 64'(0));
        check_v("rst_out_last", 64'(out_last), 64'(0));
        check_v("rst_busy", 64'(busy), 64'(0));
        check_v("rst_in_ready", 64'(in_ready), 64'(0));
        check_v("rst_out_data", 64'(out_data), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // QPSK frame, always ready: latency, header, mapping table, framing
        for (int i = 0; i < PAY; i++) pay_bits[i] = vt[i % 4].bits;
        run_frame(1'b1, 1'b0, 1'b0, -1, 1'b0);
        check_i("start_latency", first_v, 2);
        check_i("contiguous_valid", last_v - first_v + 1, FRAME);
        check_i("no_bubbles", bubbles, 0);
        check_v("end_idle_busy", 64'(end_busy), 64'(0));
        check_v("hdr_sym0", 64'(get_d(0)), 64'({NEG, ZERO12}));
        check_v("hdr_sym1", 64'(get_d(1)), 64'({POS, ZERO12}));
        check_v("hdr_sym2", 64'(get_d(2)), 64'({NEG, ZERO12}));
        for (int v = 0; v < 4; v++)
            check_v($sformatf("qpsk_map%0d", v), 64'(get_d(HDR + v)), 64'({vt[v].ei, vt[v].eq}));
        check_i("qpsk_in_xfers", in_q.size(), PAY);
        check_frame(1'b1, "qpsk");

        // BPSK frame with mode flipped to QPSK during the header
        for (int i = 0; i < PAY; i++) pay_bits[i] = vt[4 + (i % 2)].bits;
        run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0);
        for (int v = 4; v < 6; v++)
            check_v($sformatf("bpsk_map%0d", v), 64'(get_d(HDR + v - 4)), 64'({vt[v].ei, vt[v].eq}));
        check_frame(1'b0, "bpsk_flip");

        // Random backpressure with random payload
        for (int i = 0; i < PAY; i++) pay_bits[i] = 2'($urandom_range(0, 3));
        run_frame(1'b1, 1'b0, 1'b1, -1, 1'b0);
        check_i("bp_stall_stable", stall_err, 0);
        check_i("bp_in_xfers", in_q.size(), PAY);
        errs = 0;
        for (int i = 0; i < PAY; i++)
            if (i >= in_q.size() || in_q[i] !== pay_bits[i]) errs++;
        check_i("bp_in_order", errs, 0);
        check_frame(1'b1, "bp");

        // Five-cycle input underflow mid-payload
        run_frame(1'b1, 1'b0, 1'b0, 100, 1'b0);
        check_i("uf_bubbles", bubbles, 5);
        check_frame(1'b1, "uf");

        // in_valid held: exactly one idle cycle, then the next header
        run_frame(1'b0, 1'b0, 1'b0, -1, 1'b1);
        check_frame(1'b0, "hold");
        check_v("b2b_restart_busy", 64'(end_busy), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check_v("b2b_next_valid", 64'(out_valid), 64'(1));
        check_v("b2b_next_hdr", 64'(out_data), 64'({NEG, ZERO12}));

        // Reset asserted between edges in the middle of the payload
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (in_ready) found = 1;
        end
        check_i("reach_pay", found, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_v("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_v("mid_rst_valid", 64'(out_valid), 64'(0));
        check_v("mid_rst_last", 64'(out_last), 64'(0));
        check_v("mid_rst_busy", 64'(busy), 64'(0));
        check_v("mid_rst_data", 64'(out_data), 64'(0));
        check_v("mid_rst_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Frame after reset restarts from the seeded header
        for (int i = 0; i < PAY; i++) pay_bits[i] = 2'($urandom_range(0, 3));
        run_frame(1'b1, 1'b0, 1'b0, -1, 1'b0);
        check_frame(1'b1, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
